tow_bot: RTL and testbench
==========================

Name: tow_bot

Overview:
- Automated player for the tug-of-war game (tow).
- Watches the game's 7-bit LED bus and reacts to each prompt (dark -> lit position) after a programmable reaction delay.
- On reaction, drives a one-cycle button pulse onto pbl or pbr, depending on which side it plays.
- Used as a sparring opponent on the board and as a self-checking stimulus source for system benches.

Parameters:
- SIDE, 0, 0 = bot plays left (pulses like pbl), 1 = bot plays right (pulses like pbr).
- REACT_CYCLES, 16, base delay in clocks from prompt detection to press; legal range 1..65535.
- CNT_W, 16, width of the reaction down-counter; must hold REACT_CYCLES plus jitter.
- JITTER_MASK, 8'h0F, mask applied to LFSR output when jitter is compiled in.
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- led_in  in  7  LED bus from tow, bit 6 = L3 ... bit 0 = R3
- enable  in  1  bot may press when high
- pb_out  out  1  button pulse to tow (pbl or pbr per SIDE)
- armed  out  1  high while a reaction countdown is running
- press_cnt  out  8  saturating count of presses issued since reset

Behaviour:
- Reset: synchronous, active-high.
  - While rst = 1 at a clk edge: pb_out = 0, armed = 0, press_cnt = 0, state = IDLE, counter = 0, LFSR = LFSR_SEED.
  - Reset mid-countdown cancels the press.
- LED classification (combinational, registered led_prev = previous led_in):
  - Position patterns: N0 = 0001000, L1 = 0010000, L2 = 0100000, L3 = 1000000, R1 = 0000100, R2 = 0000010, R3 = 0000001.
  - Terminal patterns: WL = 1110000, WR = 0000111, RST = 1010101.
  - DARK = 0000000; anything else = INVALID.
- Prompt: led_prev == DARK and led_in is a position pattern.
- States:
  - IDLE:
    - If led_in is terminal -> HALT.
    - Else on prompt with enable = 1 -> WAIT: load counter with REACT_CYCLES-1 (+ jitter if compiled), armed = 1.
    - Prompt with enable = 0 is ignored; stay IDLE.
  - WAIT: counter decrements by 1 per clock. Abort to IDLE (armed = 0, no press, press_cnt unchanged) on any of:
    - led_in leaves the prompted pattern (includes DARK or a terminal pattern);
    - enable drops.
  - WAIT exit to PRESS: counter == 0 and no abort condition.
  - PRESS: pb_out = 1 for exactly one cycle, armed = 0, press_cnt += 1 (saturates at 255); next -> COOL.
  - COOL: pb_out = 0; wait until led_in == DARK, then -> IDLE. This guarantees one press per prompt even if the LED stays lit.
  - HALT: pb_out = 0; leave to IDLE only when led_in == DARK. Covers the win and reset display; the post-reset dark phase re-arms the bot.
  - INVALID led_in in any state: treated as "not the prompted pattern" (aborts WAIT); otherwise ignored.
- Timing:
  - Prompt visible at edge k -> pb_out high during the cycle after edge k + REACT_CYCLES; total latency REACT_CYCLES + 1 clocks.
  - REACT_CYCLES = 1 gives press one cycle after WAIT entry.
- Simultaneous events:
  - Abort condition and counter == 0 in the same cycle: abort wins.
  - A prompt detected in the same cycle as exiting HALT is not taken; a new dark -> lit edge is required.
- pb_out is registered, glitch-free, and never high for more than one consecutive cycle.

Optional Feature:
- Macro: TOW_BOT_JITTER_EN.
- Defined:
  - 8-bit Galois LFSR (taps 8,6,5,4) advances every clock; reset value LFSR_SEED.
  - On prompt, (lfsr & JITTER_MASK) is added to the load value, giving delay REACT_CYCLES .. REACT_CYCLES + JITTER_MASK.
- Undefined: no LFSR is instantiated; delay is exactly REACT_CYCLES.

Decomposition:
- Package tow_pkg:
  - 7-bit LED pattern constants: N0, L1-L3, R1-R3, WL, WR, RST_PAT, DARK.
  - tow_bot state encoding: IDLE, WAIT, PRESS, COOL, HALT.
  - SIDE_LEFT and SIDE_RIGHT constants.
- Sub-module tow_lfsr8: 8-bit LFSR with clk, rst, seed; instantiated only under TOW_BOT_JITTER_EN.

Test Plan (REACT_CYCLES = 4, jitter off unless stated):
1. rst 1 for 2 cycles, led_in = 1010101 then 0000000 then 0001000, enable = 1 -> pb_out pulses once, exactly 5 clocks after the 0001000 edge; press_cnt = 1.
2. Prompt 0010000, then led_in returns to 0000000 after 2 clocks -> no pulse, armed falls the next cycle, press_cnt unchanged.
3. Prompt 0000100 held lit for 50 clocks -> exactly one pb_out pulse, state stays COOL until dark.
4. led_in = 1110000 (WL) -> no pulse for 100 clocks; then 0000000, then 0001000 -> pulse 5 clocks later.
5. enable = 0 at prompt -> no pulse; enable dropped at count 2 in WAIT -> abort, no pulse; 300 valid prompts -> press_cnt saturates at 255.
6. TOW_BOT_JITTER_EN with JITTER_MASK = 8'h0F -> over 64 prompts every press latency lies in 5..20 clocks and the sequence matches a reference LFSR seeded with 8'hA5.

Source files
------------

// File: rtl/tow_pkg.sv
// tow_pkg: LED bus patterns, bot state encoding and side constants shared by the
// tug-of-war game and its automated player.
package tow_pkg;

    localparam logic [6:0] N0      = 7'b0001000;
    localparam logic [6:0] L1      = 7'b0010000;
    localparam logic [6:0] L2      = 7'b0100000;
    localparam logic [6:0] L3      = 7'b1000000;
    localparam logic [6:0] R1      = 7'b0000100;
    localparam logic [6:0] R2      = 7'b0000010;
    localparam logic [6:0] R3      = 7'b0000001;
    localparam logic [6:0] WL      = 7'b1110000;
    localparam logic [6:0] WR      = 7'b0000111;
    localparam logic [6:0] RST_PAT = 7'b1010101;
    localparam logic [6:0] DARK    = 7'b0000000;

    localparam int SIDE_LEFT  = 0;
    localparam int SIDE_RIGHT = 1;

    typedef enum logic [2:0] {IDLE, WAIT, PRESS, COOL, HALT} bot_state_t;

    function automatic logic is_position(input logic [6:0] p);
        return p inside {N0, L1, L2, L3, R1, R2, R3};
    endfunction

    function automatic logic is_terminal(input logic [6:0] p);
        return p inside {WL, WR, RST_PAT};
    endfunction

endpackage

// File: rtl/tow_lfsr8.sv
// tow_lfsr8: free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), reloads seed on rst.
module tow_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk)
        lfsr <= rst ? seed : {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

endmodule

// File: rtl/tow_bot.sv
// tow_bot: automated tug-of-war player; presses its button a fixed delay after each LED prompt.
// Define TOW_BOT_JITTER_EN to add LFSR-masked random jitter to the reaction delay.
module tow_bot
    import tow_pkg::*;
#(
    parameter int         SIDE         = SIDE_LEFT,
    parameter int         REACT_CYCLES = 16,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] JITTER_MASK  = 8'h0F,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led_in,
    input  logic       enable,
    output logic       pb_out,
    output logic       armed,
    output logic [7:0] press_cnt
);

    bot_state_t       state;
    logic [6:0]       led_prev;
    logic [6:0]       led_pat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load;
    logic             prompt;
    logic             abort;

    // SIDE only selects which button the output is wired to; catch bad parameter sets early.
    if ((SIDE != SIDE_LEFT && SIDE != SIDE_RIGHT) || REACT_CYCLES < 1 || REACT_CYCLES > 65535 ||
        LFSR_SEED == 8'h00 || REACT_CYCLES - 1 + int'(JITTER_MASK) > 2**CNT_W - 1) begin : g_bad_cfg
        $error("tow_bot: illegal parameter set");
    end

`ifdef TOW_BOT_JITTER_EN
    logic [7:0] lfsr;

    tow_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .lfsr (lfsr)
    );

    assign load = CNT_W'(REACT_CYCLES - 1) + CNT_W'(lfsr & JITTER_MASK);
`else
    assign load = CNT_W'(REACT_CYCLES - 1);
`endif

    // Invalid and terminal patterns both count as leaving the prompted position.
    always_comb begin
        prompt = led_prev == DARK && is_position(led_in);
        abort  = led_in != led_pat || !enable;
    end

    always_ff @(posedge clk) begin
        led_prev <= led_in;
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            led_pat   <= DARK;
            pb_out    <= 1'b0;
            armed     <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            pb_out <= 1'b0;
            case (state)
                IDLE:
                    if (is_terminal(led_in)) begin
                        state <= HALT;
                    end else if (prompt && enable) begin
                        state   <= WAIT;
                        cnt     <= load;
                        led_pat <= led_in;
                        armed   <= 1'b1;
                    end
                WAIT:
                    if (abort) begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= PRESS;
                        armed     <= 1'b0;
                        pb_out    <= 1'b1;
                        press_cnt <= press_cnt + {7'd0, press_cnt != 8'hFF};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                PRESS:
                    state <= COOL;
                COOL, HALT:
                    if (led_in == DARK) state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tow_bot.sv
// tb_tow_bot: randomized scoreboard bench for tow_bot; the driver predicts press times from
// prompt hold/enable durations and a separate monitor checks pb_out, armed and press_cnt.
module tb_tow_bot;
    import tow_pkg::*;

    localparam int R = 4;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] led_in = RST_PAT;
    logic       enable = 1'b1;
    logic       pb_out;
    logic       armed;
    logic [7:0] press_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   presses = 0;
    int   cur_cnt = 0;
    int   a_lo = 1;
    int   a_hi = 0;
    logic prev_pb = 1'b0;
    exp_t exp_q[$];

    logic [6:0] pos_tab[7] = '{N0, L1, L2, L3, R1, R2, R3};
    logic [6:0] term_tab[3] = '{WL, WR, RST_PAT};

    tow_bot #(
        .SIDE         (SIDE_LEFT),
        .REACT_CYCLES (R),
        .CNT_W        (16),
        .JITTER_MASK  (8'h0F),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .enable    (enable),
        .pb_out    (pb_out),
        .armed     (armed),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef TOW_BOT_JITTER_EN
    logic [7:0] ref_lfsr;
    always @(posedge clk) begin
        if (rst) ref_lfsr <= 8'hA5;
        else     ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 8'hB8 : 8'h00);
    end
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Prompt pat, hold it h cycles then show after; enable drops after d cycles (0 = low at prompt).
    // A press is due only if both last beyond the reaction delay.
    task automatic episode(input logic [6:0] pat, input int h, input int d, input logic [6:0] after);
        int c, j, m;
        c = cyc;
        j = 0;
`ifdef TOW_BOT_JITTER_EN
        j = int'(ref_lfsr & 8'h0F);
`endif
        m = h < d ? h : d;
        if (d > 0) begin
            a_lo = c + 1;
            a_hi = c + (m < R + j ? m : R + j);
        end
        if (d > 0 && m >= R + 1 + j) begin
            presses++;
            exp_q.push_back('{c + R + 1 + j, presses > 255 ? 255 : presses});
        end
        led_in = pat;
        enable = d > 0;
        for (int i = 1; i <= h; i++) begin
            tick();
            if (i == d) enable = 1'b0;
            if (i == h) led_in = after;
        end
        if (after != DARK) begin
            tick();
            led_in = DARK;
        end
        enable = 1'b1;
        repeat (3) tick();
    endtask

    task automatic terminal(input logic [6:0] pat, input int n);
        led_in = pat;
        repeat (n) tick();
        led_in = DARK;
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cur_cnt = 0;
            prev_pb = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("press_missing", -1, exp_q[0].cyc);
                cur_cnt = exp_q[0].cnt;
                void'(exp_q.pop_front());
            end
            if (pb_out) begin
                chk("pb_double", int'(prev_pb), 0);
                if (exp_q.size() == 0) begin
                    chk("press_unexpected", 1, 0);
                end else begin
                    chk("press_time", cyc, exp_q[0].cyc);
                    if (exp_q[0].cyc == cyc) begin
                        cur_cnt = exp_q[0].cnt;
                        void'(exp_q.pop_front());
                    end
                end
            end
            chk("press_cnt", int'(press_cnt), cur_cnt);
            chk("armed", int'(armed), int'(cyc >= a_lo && cyc <= a_hi));
            prev_pb = pb_out;
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_pb_out", int'(pb_out), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_press_cnt", int'(press_cnt), 0);
        rst = 1'b0;
        led_in = DARK;
        repeat (2) tick();

        episode(N0, 10, 100, DARK);
        episode(L1, 2, 100, DARK);
        episode(R1, 50, 100, DARK);
        terminal(WL, 100);
        episode(N0, 10, 100, DARK);
        episode(L2, 10, 0, DARK);
        episode(R2, 20, 2, DARK);
        episode(L3, R + 1, 100, DARK);
        episode(R3, R, 100, DARK);
        episode(N0, 3, 100, 7'b0011000);

        for (int n = 0; n < 40; n++) begin
            logic [6:0] p;
            p = pos_tab[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0: episode(p, $urandom_range(1, 25), 100, DARK);
                1: episode(p, $urandom_range(8, 25), $urandom_range(0, 6), DARK);
                2: episode(p, $urandom_range(1, 6), 100, 7'b1100011);
                default: terminal(term_tab[$urandom_range(0, 2)], $urandom_range(1, 10));
            endcase
        end

        repeat (300) episode(pos_tab[$urandom_range(0, 6)], 22, 100, DARK);
        chk("press_cnt_sat", int'(press_cnt), 255);

        // Reset in the middle of a countdown must cancel the pending press.
        led_in = L2;
        a_lo = cyc + 1;
        a_hi = cyc + 10;
        repeat (2) tick();
        rst = 1'b1;
        a_lo = 1;
        a_hi = 0;
        presses = 0;
        repeat (2) tick();
        rst = 1'b0;
        led_in = DARK;
        repeat (30) tick();
        chk("rst_mid_press_cnt", int'(press_cnt), 0);
        episode(N0, 10, 100, DARK);
        repeat (10) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
